// File: rtl/mem_ctrl.sv
`timescale 1ns/1ps
// Memory-stage controller: lane steering, load extension and misalignment rejection for a block RAM port.
// Stores and rejected requests complete in the issue cycle; loads return RD_LAT cycles after issue.
// Holds stall high from load issue until the result cycle; upstream keeps its inputs stable meanwhile.
module mem_ctrl #(
    parameter int RAM_AW = 14,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       wr_data,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [1:0]        mem_size,
    input  logic              mem_signed,
    output logic              stall,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    output logic              misalign,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic [1:0]        lat_cnt_q, lat_cnt_d;
    logic [1:0]        off_q;
    logic [1:0]        size_q;
    logic              sgn_q;
    logic [RAM_AW-1:0] addr_q;
    logic              load_go;
    logic              aligned;
    logic              req;
    logic [3:0]        we_mask;
    logic [31:0]       wdata_rep;
    logic [31:0]       shifted;
    logic [31:0]       load_fmt;

    // Address bits above the RAM window are dropped so accesses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_addr[31:RAM_AW+2];

    // Requests are gated by reset so a held request cannot reach the RAM while reset is asserted.
    assign req = rst_n & (mem_rd | mem_wr);

    always_comb begin
        aligned   = 1'b0;
        we_mask   = 4'b1111;
        wdata_rep = wr_data;
        case (mem_size)
            2'b00: begin
                aligned   = 1'b1;
                we_mask   = 4'b0001 << mem_addr[1:0];
                wdata_rep = {4{wr_data[7:0]}};
            end
            2'b01: begin
                aligned   = ~mem_addr[0];
                we_mask   = 4'b0011 << mem_addr[1:0];
                wdata_rep = {2{wr_data[15:0]}};
            end
            2'b10: begin
                aligned   = (mem_addr[1:0] == 2'b00);
            end
            default: begin
                aligned   = 1'b0;
            end
        endcase
    end

    // Aligned halves have off_q[0] = 0, so one byte-granular shift serves both byte and half lanes.
    assign shifted = ram_rdata >> {off_q, 3'b000};

    always_comb begin
        case (size_q)
            2'b00:   load_fmt = {{24{sgn_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_fmt = {{16{sgn_q & shifted[15]}}, shifted[15:0]};
            default: load_fmt = ram_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        stall     = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = 32'h0;
        misalign  = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 4'b0000;
        ram_wdata = 32'h0;
        ram_addr  = addr_q;
        load_go   = 1'b0;
        case (state_q)
            IDLE: begin
                ram_addr = mem_addr[RAM_AW+1:2];
                if (req && !aligned) begin
                    misalign = 1'b1;
                end else if (req && mem_wr) begin
                    ram_en    = 1'b1;
                    ram_we    = we_mask;
                    ram_wdata = wdata_rep;
                end else if (req) begin
                    ram_en    = 1'b1;
                    stall     = 1'b1;
                    load_go   = 1'b1;
                    lat_cnt_d = LAT_INIT;
                    state_d   = (RD_LAT == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                stall     = 1'b1;
                lat_cnt_d = lat_cnt_q - 2'd1;
                if (lat_cnt_q <= 2'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rd_valid = 1'b1;
                rd_data  = load_fmt;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lat_cnt_q <= 2'd0;
            off_q     <= 2'd0;
            size_q    <= 2'd0;
            sgn_q     <= 1'b0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            if (load_go) begin
                off_q  <= mem_addr[1:0];
                size_q <= mem_size;
                sgn_q  <= mem_signed;
                addr_q <= mem_addr[RAM_AW+1:2];
            end
        end
    end

endmodule
